if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage for the single-issue MIPS pipeline. Owns the PC register,
//   drives the address into the combinational instruction memory, and captures the
//   returned word into the IF/ID pipeline register. Accepts stall from hazard control
//   and taken-branch/jump redirects from EX.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC value loaded on reset; must be word aligned
// PORTS
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high reset
//   stall        in   1   hold PC and IF/ID contents this cycle
//   redirect     in   1   taken branch/jump from EX; flushes IF/ID
//   redirect_pc  in  32   target address for redirect
//   imem_pc      out 32   address to instruction memory (= PC register)
//   imem_instr   in  32   instruction word returned combinationally by instruction memory
//   ifid_valid   out  1   IF/ID holds a real instruction
//   ifid_pc      out 32   address of the instruction in IF/ID
//   ifid_pc4     out 32   ifid_pc + 4, for link/branch arithmetic
//   ifid_instr   out 32   instruction word in IF/ID; 32'h0 (NOP) when invalid
//   fetch_fault  out  1   misaligned redirect trap (see CONFIGURATION)
// BEHAVIOUR
//   - imem_pc is the registered PC; no combinational path from any input to imem_pc.
//   - Reset: PC<=RESET_PC; ifid_valid<=0; ifid_pc<=0; ifid_pc4<=0; ifid_instr<=0;
//     fetch_fault<=0. Reset takes priority over every other input.
//   - Latency: the word at address A appears on ifid_* at the edge after imem_pc==A.
//     First edge after reset deasserts captures RESET_PC with ifid_valid=1.
//   - Per-edge priority: reset > redirect > stall > normal.
//   - Normal: IF/ID <= {1, PC, PC+4, imem_instr}; PC <= PC+4.
//   - Stall: PC and all ifid_* hold their values.
//   - Redirect: PC <= redirect_pc; IF/ID <= bubble (valid=0, instr=0, pc/pc4 hold).
//     Redirect wins over a simultaneous stall; the younger instruction in IF/ID is on
//     the wrong path and is discarded.
//   - Arithmetic: 32-bit unsigned, modulo 2^32; PC 32'hFFFF_FFFC + 4 wraps to 0.
//   - ifid_pc4 is always exactly ifid_pc + 4 whenever ifid_valid=1.
//   - Reset asserted mid-stream: the next edge yields reset state, with no partial
//     update of IF/ID.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//     - redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until reset).
//     - PC <= {redirect_pc[31:2],2'b00}. PC then freezes.
//     - ifid_valid stays 0; stall and redirect are ignored until reset.
//   MISALIGN_TRAP_EN undefined:
//     - redirect_pc[1:0] silently cleared; fetch_fault tied to 0.
// TESTING (imem model: 0:0x00000820, 4:0x2001000A, 8:0x20020014, 12:0x00221820)
//   1. Reset, 4 free-running cycles -> ifid_pc 0,4,8,12 with the matching words,
//      ifid_pc4 4,8,12,16, ifid_valid=1 from first edge.
//   2. stall=1 for 2 cycles while imem_pc==8 -> imem_pc stays 8, ifid_pc=4 and
//      instr=0x2001000A held; release -> ifid_pc=8, instr=0x20020014.
//   3. redirect=1, redirect_pc=0x40 while imem_pc==12 -> next edge: ifid_valid=0,
//      ifid_instr=0, imem_pc=0x40; following edge: ifid_pc=0x40, valid=1.
//   4. redirect=1 and stall=1 together, redirect_pc=0x80 -> imem_pc=0x80,
//      ifid_valid=0 (redirect wins).
//   5. RESET_PC=32'hFFFF_FFF8, free run -> imem_pc FFFFFFF8, FFFFFFFC, 0, 4; no X.
//   6. reset=1 for one cycle mid-stream -> all outputs at reset values next edge.
//      Plus, with MISALIGN_TRAP_EN: redirect_pc=0x42 -> fetch_fault=1,
//      imem_pc=0x40 frozen, ifid_valid=0 until reset.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address, IF/ID register.
// Optional MISALIGN_TRAP_EN: a misaligned redirect raises a sticky fetch_fault and freezes fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        fetch_fault
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            frozen;

  assign pc_plus4 = pc + XLEN'(4);
  // Low address bits are always dropped; the trap build inspects them separately.
  assign target   = redirect_pc & ~XLEN'(3);
  assign imem_pc  = pc;

`ifdef MISALIGN_TRAP_EN
  logic fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (!fault && redirect && (redirect_pc[1:0] != 2'b00)) begin
      fault <= 1'b1;
    end
  end

  assign frozen      = fault;
  assign fetch_fault = fault;
`else
  assign frozen      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Priority: reset > frozen > redirect > stall > normal fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_pc4   <= '0;
      ifid_instr <= '0;
    end else if (!frozen) begin
      if (redirect) begin
        pc         <= target;
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
      end else if (!stall) begin
        pc         <= pc_plus4;
        ifid_valid <= 1'b1;
        ifid_pc    <= pc;
        ifid_pc4   <= pc_plus4;
        ifid_instr <= imem_instr;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, redirect, wrap-around, reset and
// (when MISALIGN_TRAP_EN is defined) the misaligned-redirect trap.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc, imem_instr;
  logic        ifid_valid, fetch_fault;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr;

  logic        reset1;
  logic [31:0] imem_pc1, imem_instr1;
  logic        ifid_valid1, fetch_fault1;
  logic [31:0] ifid_pc1, ifid_pc41, ifid_instr1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0820;
      32'd4:   return 32'h2001_000A;
      32'd8:   return 32'h2002_0014;
      32'd12:  return 32'h0022_1820;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign imem_instr  = imem(imem_pc);
  assign imem_instr1 = imem(imem_pc1);

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_instr(ifid_instr), .fetch_fault(fetch_fault)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset1), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_pc(imem_pc1), .imem_instr(imem_instr1),
    .ifid_valid(ifid_valid1), .ifid_pc(ifid_pc1), .ifid_pc4(ifid_pc41),
    .ifid_instr(ifid_instr1), .fetch_fault(fetch_fault1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full IF/ID register and the current fetch address.
  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] p,
                          input logic [31:0] p4, input logic [31:0] ins,
                          input logic [31:0] ipc);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'(v));
    chk({tag, ".pc"},    ifid_pc,  p);
    chk({tag, ".pc4"},   ifid_pc4, p4);
    chk({tag, ".instr"}, ifid_instr, ins);
    chk({tag, ".imem_pc"}, imem_pc, ipc);
  endtask

  initial begin
    reset = 1'b1; reset1 = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step();
    chk_ifid("rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rst.fault", 32'(fetch_fault), 32'h0);
    chk("wrap.rst.imem_pc", imem_pc1, 32'hFFFF_FFF8);
    chk("wrap.rst.valid", 32'(ifid_valid1), 32'h0);

    // Free run from reset; wrap instance crosses 2^32.
    reset = 1'b0; reset1 = 1'b0;
    step();
    chk_ifid("run0", 1'b1, 32'd0, 32'd4, 32'h0000_0820, 32'd4);
    chk("wrap1.imem_pc", imem_pc1, 32'hFFFF_FFFC);
    chk("wrap1.ifid_pc", ifid_pc1, 32'hFFFF_FFF8);
    chk("wrap1.ifid_pc4", ifid_pc41, 32'hFFFF_FFFC);
    step();
    chk_ifid("run4", 1'b1, 32'd4, 32'd8, 32'h2001_000A, 32'd8);
    chk("wrap2.imem_pc", imem_pc1, 32'h0);
    chk("wrap2.ifid_pc", ifid_pc1, 32'hFFFF_FFFC);
    chk("wrap2.ifid_pc4", ifid_pc41, 32'h0);
    step();
    chk_ifid("run8", 1'b1, 32'd8, 32'd12, 32'h2002_0014, 32'd12);
    chk("wrap3.imem_pc", imem_pc1, 32'h4);
    chk("wrap3.ifid_instr", ifid_instr1, 32'h0000_0820);
    chk("wrap3.fault", 32'(fetch_fault1), 32'h0);
    step();
    chk_ifid("run12", 1'b1, 32'd12, 32'd16, 32'h0022_1820, 32'd16);

    // Mid-stream reset with a redirect pending: reset must win.
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    chk_ifid("midrst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0; redirect = 1'b0;
    step();
    chk_ifid("re0", 1'b1, 32'd0, 32'd4, 32'h0000_0820, 32'd4);
    step();
    chk_ifid("re4", 1'b1, 32'd4, 32'd8, 32'h2001_000A, 32'd8);

    // Stall two cycles while imem_pc == 8.
    stall = 1'b1;
    step();
    chk_ifid("stall1", 1'b1, 32'd4, 32'd8, 32'h2001_000A, 32'd8);
    step();
    chk_ifid("stall2", 1'b1, 32'd4, 32'd8, 32'h2001_000A, 32'd8);
    stall = 1'b0;
    step();
    chk_ifid("unstall", 1'b1, 32'd8, 32'd12, 32'h2002_0014, 32'd12);

    // Redirect to 0x40 while imem_pc == 12: bubble, pc/pc4 hold.
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    chk_ifid("redir", 1'b0, 32'd8, 32'd12, 32'h0, 32'h40);
    redirect = 1'b0;
    step();
    chk_ifid("redir.tgt", 1'b1, 32'h40, 32'h44, 32'hA5A5_0040, 32'h44);

    // Redirect with simultaneous stall: redirect wins.
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h80;
    step();
    chk_ifid("redir_stall", 1'b0, 32'h40, 32'h44, 32'h0, 32'h80);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk_ifid("redir_stall.tgt", 1'b1, 32'h80, 32'h84, 32'hA5A5_0080, 32'h84);

    // Misaligned redirect target.
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
`ifdef MISALIGN_TRAP_EN
    chk_ifid("trap", 1'b0, 32'h80, 32'h84, 32'h0, 32'h40);
    chk("trap.fault", 32'(fetch_fault), 32'h1);
    redirect_pc = 32'h100;
    step();
    chk_ifid("trap.frz_redir", 1'b0, 32'h80, 32'h84, 32'h0, 32'h40);
    redirect = 1'b0;
    step();
    chk_ifid("trap.frz_run", 1'b0, 32'h80, 32'h84, 32'h0, 32'h40);
    chk("trap.sticky", 32'(fetch_fault), 32'h1);
`else
    chk_ifid("misal", 1'b0, 32'h80, 32'h84, 32'h0, 32'h40);
    chk("misal.fault", 32'(fetch_fault), 32'h0);
    redirect = 1'b0;
    step();
    chk_ifid("misal.tgt", 1'b1, 32'h40, 32'h44, 32'hA5A5_0040, 32'h44);
    chk("misal.fault2", 32'(fetch_fault), 32'h0);
`endif

    // Final reset clears everything, including any trap.
    reset = 1'b1;
    step();
    chk_ifid("endrst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("endrst.fault", 32'(fetch_fault), 32'h0);
    reset = 1'b0;
    step();
    chk_ifid("endrst.run", 1'b1, 32'd0, 32'd4, 32'h0000_0820, 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
